// File: rtl/instruction_encoder.sv
// rtl/instruction_encoder.sv - queued command encoder issuing dataA/dataB words to a decoder via a clk_en strobe
module instruction_encoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [3:0]                    cmd_opcode,
    input  logic [13:0]                   cmd_register,
    input  logic [31:0]                   cmd_data,
    output logic [31:0]                   dataA,
    output logic [31:0]                   dataB,
    output logic                          clk_en,
    input  logic                          new_instruction,
    output logic                          cmd_error,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t state, state_nxt;

    logic [3:0]       q_opcode   [FIFO_DEPTH];
    logic [13:0]      q_register [FIFO_DEPTH];
    logic [31:0]      q_data     [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;

    logic        accept, legal, push, pop, load;
    logic [3:0]  head_opcode;
    logic [13:0] head_register;
    logic [31:0] head_data;
    logic [31:0] enc_a, enc_b;

    assign cmd_ready = (fifo_count < CNT_W'(FIFO_DEPTH));
    assign accept    = cmd_valid && cmd_ready;
    assign legal     = (cmd_opcode[3:2] == 2'b00);
    assign push      = accept && legal;
    assign clk_en    = (state == STROBE);

    assign head_opcode   = q_opcode[rd_ptr];
    assign head_register = q_register[rd_ptr];
    assign head_data     = q_data[rd_ptr];

    // Queue storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            q_opcode[wr_ptr]   <= cmd_opcode;
            q_register[wr_ptr] <= cmd_register;
            q_data[wr_ptr]     <= cmd_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            cmd_error  <= 1'b0;
        end else begin
            cmd_error <= accept && !legal;
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_comb begin
        enc_a      = '0;
        enc_b      = '0;
        enc_a[3:0] = head_opcode;
        case (head_opcode)
            4'd0, 4'd2: begin
                enc_a[8:4] = head_register[4:0];
                enc_b      = head_data;
            end
            4'd1: begin
                enc_a[17:4] = head_register;
                enc_b       = head_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            dataA <= '0;
            dataB <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                dataA <= enc_a;
                dataB <= enc_b;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if ((fifo_count != '0) && !new_instruction) begin
                    state_nxt = SETUP;
                    load      = 1'b1;
                end
            end
            SETUP: begin
                if (!new_instruction)
                    state_nxt = STROBE;
            end
            STROBE: state_nxt = HOLD;
            HOLD: begin
                state_nxt = IDLE;
                pop       = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_instruction_encoder.sv
// tb/tb_instruction_encoder.sv - directed self-checking bench for instruction_encoder
module tb_instruction_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_opcode = '0;
    logic [13:0] cmd_register = '0;
    logic [31:0] cmd_data = '0;
    logic [31:0] dataA, dataB;
    logic        clk_en;
    logic        new_instruction = 1'b0;
    logic        cmd_error;
    logic [2:0]  fifo_count;

    int n_checks = 0;
    int n_fail   = 0;

    instruction_encoder #(.FIFO_DEPTH(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_opcode      (cmd_opcode),
        .cmd_register    (cmd_register),
        .cmd_data        (cmd_data),
        .dataA           (dataA),
        .dataB           (dataB),
        .clk_en          (clk_en),
        .new_instruction (new_instruction),
        .cmd_error       (cmd_error),
        .fifo_count      (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] op, input logic [13:0] rg, input logic [31:0] d);
        @(negedge clk);
        cmd_valid    = 1'b1;
        cmd_opcode   = op;
        cmd_register = rg;
        cmd_data     = d;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic issue_check(input string tag, input logic [3:0] op, input logic [13:0] rg,
                               input logic [31:0] d, input logic [31:0] ea, input logic [31:0] eb);
        send(op, rg, d);
        check({tag, "_count_e0"}, fifo_count, 32'd1);
        @(negedge clk);
        check({tag, "_dataA"}, dataA, ea);
        check({tag, "_dataB"}, dataB, eb);
        check({tag, "_clken_e1"}, clk_en, 32'd0);
        @(negedge clk);
        check({tag, "_clken_e2"}, clk_en, 32'd1);
        @(negedge clk);
        check({tag, "_clken_e3"}, clk_en, 32'd0);
        check({tag, "_count_e3"}, fifo_count, 32'd1);
        @(negedge clk);
        check({tag, "_count_e4"}, fifo_count, 32'd0);
    endtask

    initial begin
        int strobes;
        int last_cyc;
        int cyc;
        logic seen;
        logic [31:0] held_a, held_b;

        // Reset values while reset is held low
        repeat (2) @(negedge clk);
        check("rst_ready", cmd_ready, 32'd1);
        check("rst_clken", clk_en, 32'd0);
        check("rst_count", fifo_count, 32'd0);
        check("rst_dataA", dataA, 32'd0);
        check("rst_dataB", dataB, 32'd0);
        check("rst_error", cmd_error, 32'd0);
        reset = 1'b1;

        issue_check("op0", 4'd0, 14'h0005, 32'h0064_0032, 32'h0000_0050, 32'h0064_0032);
        issue_check("op1", 4'd1, 14'h3FFF, 32'h0000_01FF, 32'h0003_FFF1, 32'h0000_01FF);
        issue_check("op2", 4'd2, 14'h3FE3, 32'hDEAD_BEEF, 32'h0000_0032, 32'hDEAD_BEEF);
        issue_check("op3", 4'd3, 14'h1234, 32'h0000_0055, 32'h0000_0003, 32'h0000_0000);

        // Illegal opcode
        send(4'd7, 14'h0001, 32'h1111_1111);
        check("bad_error_pulse", cmd_error, 32'd1);
        check("bad_count", fifo_count, 32'd0);
        seen = 1'b0;
        @(negedge clk);
        check("bad_error_end", cmd_error, 32'd0);
        repeat (5) begin
            @(negedge clk);
            if (clk_en) seen = 1'b1;
        end
        check("bad_no_strobe", seen, 32'd0);

        // Fill with decoder busy; fifth offer ignored
        new_instruction = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 4) check("full_ready", cmd_ready, 32'd0);
            cmd_valid    = 1'b1;
            cmd_opcode   = 4'd0;
            cmd_register = 14'(i + 1);
            cmd_data     = 32'h100 + 32'(i);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        check("full_count", fifo_count, 32'd4);
        check("full_error", cmd_error, 32'd0);
        new_instruction = 1'b0;
        strobes  = 0;
        last_cyc = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (clk_en) begin
                if (strobes < 4) begin
                    check($sformatf("drain_dataB_%0d", strobes), dataB, 32'h100 + 32'(strobes));
                    check($sformatf("drain_dataA_%0d", strobes), dataA, 32'(strobes + 1) << 4);
                end
                if (strobes > 0) check($sformatf("drain_gap_%0d", strobes), 32'(c - last_cyc), 32'd4);
                last_cyc = c;
                strobes++;
            end
        end
        check("drain_strobes", 32'(strobes), 32'd4);
        check("drain_count", fifo_count, 32'd0);

        // Decoder busy during SETUP
        send(4'd2, 14'h0007, 32'hCAFE_0001);
        @(negedge clk);
        held_a = dataA;
        held_b = dataB;
        check("stall_dataA_load", held_a, 32'h0000_0072);
        new_instruction = 1'b1;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (clk_en) seen = 1'b1;
            check("stall_dataA_hold", dataA, 32'h0000_0072);
            check("stall_dataB_hold", dataB, 32'hCAFE_0001);
        end
        check("stall_no_strobe", seen, 32'd0);
        new_instruction = 1'b0;
        @(negedge clk);
        check("stall_strobe", clk_en, 32'd1);
        repeat (2) @(negedge clk);
        check("stall_count", fifo_count, 32'd0);

        // Push and pop on the same edge
        send(4'd0, 14'h0001, 32'h0000_000A);
        @(negedge clk);
        @(negedge clk);
        check("pp_strobeA", clk_en, 32'd1);
        check("pp_dataB_A", dataB, 32'h0000_000A);
        @(negedge clk);
        cmd_valid    = 1'b1;
        cmd_opcode   = 4'd0;
        cmd_register = 14'h0002;
        cmd_data     = 32'h0000_000B;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("pp_count_same", fifo_count, 32'd1);
        @(negedge clk);
        check("pp_dataA_B", dataA, 32'h0000_0020);
        check("pp_dataB_B", dataB, 32'h0000_000B);
        @(negedge clk);
        check("pp_strobeB", clk_en, 32'd1);
        repeat (2) @(negedge clk);
        check("pp_count_end", fifo_count, 32'd0);

        // Reset during STROBE with two queued
        new_instruction = 1'b1;
        send(4'd0, 14'h0003, 32'h0000_0333);
        send(4'd1, 14'h0004, 32'h0000_0444);
        check("rs_count_pre", fifo_count, 32'd2);
        new_instruction = 1'b0;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            if (clk_en) seen = 1'b1;
            cyc++;
        end
        check("rs_reached_strobe", seen, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("rs_clken", clk_en, 32'd0);
        check("rs_count", fifo_count, 32'd0);
        check("rs_dataA", dataA, 32'd0);
        check("rs_dataB", dataB, 32'd0);
        check("rs_ready", cmd_ready, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (clk_en) seen = 1'b1;
        end
        check("rs_no_strobe", seen, 32'd0);
        check("rs_count_after", fifo_count, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_encoder.md
INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, command queue depth; legal values are powers of two, 2 to 16.
REQ-002 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port cmd_valid, input, 1, a command is offered this cycle.
REQ-005 SHALL have port cmd_ready, output, 1, queue can accept a command.
REQ-006 SHALL have port cmd_opcode, input, 4, instruction opcode.
REQ-007 SHALL have port cmd_register, input, 14, register index or sprite-memory address.
REQ-008 SHALL have port cmd_data, input, 32, payload: x/y position, colour or offset.
REQ-009 SHALL have port dataA, output, 32, encoded instruction word A.
REQ-010 SHALL have port dataB, output, 32, encoded instruction word B.
REQ-011 SHALL have port clk_en, output, 1, one-cycle strobe; decoder latches dataA/dataB on its rising edge.
REQ-012 SHALL have port new_instruction, input, 1, decoder busy; high forbids issue.
REQ-013 SHALL have port cmd_error, output, 1, one-cycle pulse: illegal opcode rejected.
REQ-014 SHALL have port fifo_count, output, clog2(FIFO_DEPTH)+1, queued command count.

Function
REQ-015 SHALL accept a command on a rising edge where cmd_valid=1 and cmd_ready=1; cmd_ready = (fifo_count < FIFO_DEPTH).
REQ-016 SHALL enqueue only opcodes 0-3; for opcodes 4-15 it SHALL drop the command and drive cmd_error=1 for exactly the next cycle.
REQ-017 SHALL ignore cmd_valid while cmd_ready=0, with no enqueue and no error.
REQ-018 SHALL encode dataA[3:0]=opcode for every opcode.
REQ-019 SHALL encode opcodes 0 and 2 as dataA[8:4]=register[4:0], dataA[31:9]=0, dataB=data.
REQ-020 SHALL encode opcode 1 as dataA[17:4]=register[13:0], dataA[31:18]=0, dataB=data.
REQ-021 SHALL encode opcode 3 as dataA[31:4]=0, dataB=0.
REQ-022 SHALL run an issue FSM with states IDLE, SETUP, STROBE, HOLD.
REQ-023 SHALL move IDLE->SETUP when the queue is non-empty and new_instruction=0, and SHALL load dataA/dataB with the encoded head entry on that edge.
REQ-024 SHALL move SETUP->STROBE when new_instruction=0; while new_instruction=1 it SHALL stay in SETUP with dataA/dataB held.
REQ-025 SHALL move STROBE->HOLD unconditionally; clk_en=1 only in STROBE.
REQ-026 SHALL move HOLD->IDLE unconditionally, pop the head on that edge, and keep dataA/dataB unchanged until the next SETUP load.
REQ-027 SHALL handle push and pop on the same edge with fifo_count unchanged and FIFO order preserved.
REQ-028 SHALL give minimum latency: command accepted at edge E0, SETUP at E1, clk_en high between E2 and E3, pop at E4.
REQ-029 SHALL sustain at most one issued instruction per 4 cycles.
REQ-030 SHALL wrap read and write pointers modulo FIFO_DEPTH.

Reset
REQ-031 SHALL, while reset=0, immediately force state=IDLE, clk_en=0, dataA=0, dataB=0, cmd_error=0, fifo_count=0, and pointers=0.
REQ-032 SHALL drive cmd_ready=1 during and after reset.
REQ-033 SHALL discard queued commands on reset mid-operation, including during STROBE, with clk_en low asynchronously.
REQ-034 SHALL begin the first post-reset transition on the first rising clk after reset deasserts.

Verification
REQ-035 SHALL pass: opcode 0, register 0x0005, data 0x00640032, new_instruction=0 -> clk_en pulse in cycle E2-E3; dataA=0x00000050, dataB=0x00640032; fifo_count returns to 0 at E4.
REQ-036 SHALL pass: opcode 1, register 0x3FFF, data 0x000001FF -> dataA=0x0003FFF1, dataB=0x000001FF.
REQ-037 SHALL pass: opcode 7 offered -> not queued, cmd_error=1 for one cycle, fifo_count stays 0, no clk_en.
REQ-038 SHALL pass: 5 back-to-back commands with new_instruction=1 -> 4 queued, cmd_ready=0, 5th ignored; on releasing new_instruction, 4 strobes in order spaced 4 cycles apart.
REQ-039 SHALL pass: new_instruction raised during SETUP for 3 cycles -> no clk_en, dataA/dataB stable; strobe follows release.
REQ-040 SHALL pass: reset asserted during STROBE with 2 commands queued -> clk_en=0 at once, fifo_count=0, dataA/dataB=0, no strobes after release.
